mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between the fetch port (IF, driven by pc) and the data port (MEM, driven by memAdrs/memDataWD).
//  Sequences every access through a fixed-latency memory with a grant / response handshake.
//  The pipeline uses the handshake to raise its stall_F / stall_M signals.
//  Data port has priority; a starvation guard keeps fetch progressing.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width
//  WAIT_CYCLES  2   memory access latency in cycles (>=1)
//  MAX_D_WIN    2   consecutive data grants allowed while i_req is pending
// PORTS
//  clk       in   1       clock, rising edge
//  reset     in   1       asynchronous, active-high reset
//  i_req     in   1       fetch request; held until i_gnt
//  i_addr    in   ADDR_W  fetch address
//  i_gnt     out  1       fetch request accepted (1-cycle pulse)
//  i_rvalid  out  1       fetch data valid (1-cycle pulse)
//  i_rdata   out  DATA_W  fetch read data
//  d_req     in   1       data request; held until d_gnt
//  d_we      in   1       1 = store, 0 = load
//  d_mode    in   3       access size/sign (dmem mode encoding, passed through)
//  d_addr    in   ADDR_W  data address
//  d_wdata   in   DATA_W  store data
//  d_gnt     out  1       data request accepted (1-cycle pulse)
//  d_rvalid  out  1       data completion; load data valid (1-cycle pulse)
//  d_rdata   out  DATA_W  load data
//  m_addr    out  ADDR_W  memory address
//  m_we      out  1       memory write enable
//  m_mode    out  3       memory access mode
//  m_wdata   out  DATA_W  memory write data
//  m_rdata   in   DATA_W  memory read data
//  busy      out  1       1 in ACCESS or RESP
// BEHAVIOUR
//  FSM states: IDLE -> ACCESS -> RESP -> IDLE.
//  IDLE
//   - Arbitrates combinationally and drives the winner's gnt in the same cycle.
//   - Latches the winner's addr/we/mode/wdata and the owner ID on that edge, loads wcnt = WAIT_CYCLES-1, then enters ACCESS.
//  Arbitration
//   - d_req wins over i_req.
//   - Exception: if i_req is pending and dcnt == MAX_D_WIN, fetch wins.
//   - dcnt +1 on each data grant made while i_req=1 (saturating).
//   - dcnt clears on any fetch grant, or in IDLE with i_req=0.
//  ACCESS
//   - m_addr/m_mode/m_wdata come from the latched registers; wcnt decrements each cycle.
//   - When wcnt == 0: m_we = latched we for exactly this one cycle; m_rdata is captured into the owner's rdata register; next state is RESP.
//  RESP
//   - Owner's rvalid = 1 for one cycle; rvalid is raised for stores too.
//   - rdata holds its value until that owner's next RESP.
//   - Next state is IDLE.
//  Timing
//   - Latency from gnt to rvalid = WAIT_CYCLES+1 cycles.
//   - Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
//  Requests
//   - Requests seen in ACCESS or RESP are not granted; each requester must hold req until it sees gnt.
//   - Dropping req before gnt is legal and causes no access.
//   - gnt never asserts outside IDLE; at most one gnt per cycle.
//  m_we is 0 in IDLE and RESP. m_addr/m_mode/m_wdata hold their last values in IDLE.
//  Reset (asynchronous, any state)
//   - State = IDLE; wcnt = dcnt = 0.
//   - All outputs = 0: gnts, rvalids, rdatas, m_addr, m_we, m_mode, m_wdata, busy.
//   - An in-flight store is aborted; m_we never pulses for it.
//  WAIT_CYCLES=1: ACCESS lasts exactly one cycle.
// TESTING
//  1. WAIT_CYCLES=2. i_req=1, i_addr=0x10 at cycle 0, mem[0x10]=0x00500093.
//     -> i_gnt at c0; m_addr=0x10 at c1-c2; i_rvalid=1 with i_rdata=0x00500093 at c3.
//  2. i_req and d_req (load 0x100) both rise at c0.
//     -> d_gnt at c0; d_rvalid at c3; i_gnt at c4; i_rvalid at c7.
//  3. d_req and i_req held high continuously.
//     -> grant order D, D, I, D, D, I; dcnt never exceeds 2.
//  4. Store: d_we=1, d_mode=SW, d_addr=0x20, d_wdata=0xDEADBEEF.
//     -> m_we is high only in the last ACCESS cycle, d_rvalid follows one cycle later.
//     -> a later load from 0x20 returns 0xDEADBEEF.
//  5. Assert reset in the first ACCESS cycle of that store.
//     -> m_we never asserts, all outputs read 0, mem[0x20] is unchanged.
//     -> the next fetch completes normally.
//  6. i_req rises during a data ACCESS.
//     -> no i_gnt until IDLE, then i_gnt in the first IDLE cycle; busy=1 throughout ACCESS/RESP.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch port and the data port.
// Data port has priority; a starvation window guarantees fetch progress under data pressure.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int MAX_D_WIN   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_mode,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [2:0]        m_mode,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int WC_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int DC_W = (MAX_D_WIN < 2) ? 1 : $clog2(MAX_D_WIN + 1);
  // Fetches are always full-word loads.
  localparam logic [2:0] FETCH_MODE = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [WC_W-1:0]   r_wcnt;
  logic [DC_W-1:0]   r_dcnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [2:0]        r_mode;
  logic [DATA_W-1:0] r_wdata;
  logic              r_own_d;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;

  logic w_pick_i, w_pick_d, w_i_gnt, w_d_gnt, w_last;

  assign w_pick_i = i_req && (!d_req || (r_dcnt == DC_W'(MAX_D_WIN)));
  assign w_pick_d = d_req && !w_pick_i;
  assign w_last   = (r_state == S_ACCESS) && (r_wcnt == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_i_gnt || w_d_gnt) w_next = S_ACCESS;
      S_ACCESS: if (r_wcnt == '0) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic; grants are masked while reset is held so nothing is accepted then.
  always_comb begin
    w_i_gnt  = 1'b0;
    w_d_gnt  = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    m_we     = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_i_gnt = w_pick_i && !reset;
        w_d_gnt = w_pick_d && !reset;
      end
      S_ACCESS: begin
        busy = 1'b1;
        m_we = w_last && r_we;
      end
      S_RESP: begin
        busy     = 1'b1;
        i_rvalid = !r_own_d;
        d_rvalid = r_own_d;
      end
      default: ;
    endcase
  end

  assign i_gnt   = w_i_gnt;
  assign d_gnt   = w_d_gnt;
  assign m_addr  = r_addr;
  assign m_mode  = r_mode;
  assign m_wdata = r_wdata;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_mode  <= '0;
      r_wdata <= '0;
      r_own_d <= 1'b0;
    end else if (w_i_gnt || w_d_gnt) begin
      r_wcnt  <= WC_W'(WAIT_CYCLES - 1);
      r_addr  <= w_d_gnt ? d_addr : i_addr;
      r_we    <= w_d_gnt && d_we;
      r_mode  <= w_d_gnt ? d_mode : FETCH_MODE;
      r_wdata <= w_d_gnt ? d_wdata : '0;
      r_own_d <= w_d_gnt;
    end else if (r_state == S_ACCESS && r_wcnt != '0) begin
      r_wcnt <= r_wcnt - WC_W'(1);
    end
  end

  // Starvation window: counts data grants taken while fetch was waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_dcnt <= '0;
    else if (w_i_gnt)
      r_dcnt <= '0;
    else if (w_d_gnt && i_req && r_dcnt != DC_W'(MAX_D_WIN))
      r_dcnt <= r_dcnt + DC_W'(1);
    else if (r_state == S_IDLE && !i_req)
      r_dcnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else if (w_last) begin
      if (r_own_d) r_d_rdata <= m_rdata;
      else         r_i_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a timestamp-based transaction model.
module tb_mem_port_arbiter;
  localparam int WAIT = 2;
  localparam int MAXW = 2;

  logic        clk = 1'b0, reset;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [2:0]  d_mode, m_mode;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_we, busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAIT), .MAX_D_WIN(MAXW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_mode(m_mode), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  assign m_rdata = mem[m_addr[9:2]];
  always @(posedge clk) if (m_we) mem[m_addr[9:2]] <= m_wdata;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: one transaction at a time, described by its grant cycle.
  int          cyc, t_gnt, t_free, dc;
  bit          inflight, tx_d, tx_we;
  logic [31:0] tx_addr, tx_wdata, tx_rd, e_ird, e_drd;
  logic [2:0]  tx_mode;

  task automatic model_reset();
    inflight = 0; t_free = 0; t_gnt = 0; dc = 0; e_ird = '0; e_drd = '0;
  endtask

  task automatic model_check();
    bit idle, eig, edg;
    int rsp;
    idle = (cyc >= t_free);
    rsp  = t_gnt + WAIT + 1;
    eig = 0; edg = 0;
    if (inflight && cyc == t_gnt + WAIT && tx_we) ref_mem[tx_addr[9:2]] = tx_wdata;
    if (inflight && cyc == rsp) begin
      if (tx_d) e_drd = tx_rd; else e_ird = tx_rd;
    end
    chk("busy", busy, inflight && cyc > t_gnt && cyc < t_free);
    chk("m_we", m_we, inflight && cyc == t_gnt + WAIT && tx_we);
    chk("i_rvalid", i_rvalid, inflight && cyc == rsp && !tx_d);
    chk("d_rvalid", d_rvalid, inflight && cyc == rsp && tx_d);
    chk("i_rdata", i_rdata, e_ird);
    chk("d_rdata", d_rdata, e_drd);
    if (inflight && cyc > t_gnt && cyc <= t_gnt + WAIT) begin
      chk("m_addr", m_addr, tx_addr);
      if (tx_d) chk("m_mode", m_mode, tx_mode);
      if (tx_we) chk("m_wdata", m_wdata, tx_wdata);
    end
    if (idle) begin
      if (i_req && (!d_req || dc == MAXW)) eig = 1;
      else if (d_req) edg = 1;
    end
    chk("i_gnt", i_gnt, eig);
    chk("d_gnt", d_gnt, edg);
    if (eig || edg) begin
      inflight = 1; t_gnt = cyc; t_free = cyc + WAIT + 2; tx_d = edg;
      tx_addr = edg ? d_addr : i_addr;
      tx_we = edg && d_we; tx_wdata = d_wdata; tx_mode = d_mode;
      tx_rd = ref_mem[tx_addr[9:2]];
    end
    if (eig) dc = 0;
    else if (edg && i_req) dc = (dc + 1 > MAXW) ? MAXW : dc + 1;
    else if (idle && !i_req) dc = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(3))
      0: return 32'h10;
      1: return 32'h20;
      2: return 32'h100;
      default: return {22'd0, 8'($urandom_range(255)), 2'b00};
    endcase
  endfunction

  // Requests are held until granted; random mode may also drop a pending one.
  task automatic tick(input bit rnd);
    bit ig, dg;
    @(negedge clk);
    model_check();
    ig = i_gnt; dg = d_gnt; cyc++;
    @(posedge clk); #1;
    if (!i_req || ig) begin
      i_req = rnd && ($urandom_range(3) != 0); i_addr = rand_addr();
    end else if (rnd && $urandom_range(15) == 0) i_req = 0;
    if (!d_req || dg) begin
      d_req = rnd && ($urandom_range(2) != 0); d_addr = rand_addr();
      d_we = 1'($urandom_range(1)); d_mode = 3'($urandom_range(7)); d_wdata = $urandom;
    end else if (rnd && $urandom_range(15) == 0) d_req = 0;
  endtask

  logic [31:0] old20;

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k] = $urandom; ref_mem[k] = mem[k];
    end
    mem[4] = 32'h00500093; ref_mem[4] = 32'h00500093;
    reset = 1; i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_mode = 3'b010;
    d_addr = 32'h100; d_wdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_i_gnt", i_gnt, 0); chk("rst_d_gnt", d_gnt, 0);
    chk("rst_busy", busy, 0); chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0); chk("rst_i_rdata", i_rdata, 0);

    // Simultaneous fetch and load: data first, fetch after it.
    @(posedge clk); #1; reset = 0;
    model_reset(); cyc = 0;
    repeat (10) tick(0);
    chk("fetch_0x10", i_rdata, 32'h00500093);

    // Store then load back.
    d_req = 1; d_we = 1; d_mode = 3'b010; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    repeat (5) tick(0);
    d_req = 1; d_we = 0; d_addr = 32'h20;
    repeat (5) tick(0);
    chk("load_after_store", d_rdata, 32'hDEADBEEF);

    repeat (3000) tick(1);
    i_req = 0; d_req = 0;
    repeat (6) tick(0);

    // Reset during the first ACCESS cycle of a store aborts it.
    old20 = ref_mem[8];
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678; d_mode = 3'b010;
    tick(0);
    reset = 1; #1;
    chk("abort_busy", busy, 0); chk("abort_m_we", m_we, 0);
    chk("abort_m_addr", m_addr, 0); chk("abort_m_wdata", m_wdata, 0);
    chk("abort_m_mode", m_mode, 0); chk("abort_d_rdata", d_rdata, 0);
    chk("abort_i_rdata", i_rdata, 0); chk("abort_rvalid", {i_rvalid, d_rvalid}, 0);
    @(negedge clk); chk("abort_m_we2", m_we, 0);
    @(posedge clk); #1; reset = 0;
    model_reset();
    chk("mem20_kept", mem[8], old20);
    i_req = 1; i_addr = 32'h10; d_req = 0;
    repeat (6) tick(0);
    chk("fetch_after_reset", i_rdata, ref_mem[4]);
    chk("mem20_still_kept", mem[8], old20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
